// File: rtl/auteur_mc_fifo.sv
// Bank of NumChannels independent circular FIFOs with per-channel status,
// sticky overflow/underflow flags, synchronous flush and optional fall-through.
module auteur_mc_fifo #(
  parameter int unsigned  NumChannels = 4,
  parameter int unsigned  Depth       = 8,
  parameter int unsigned  DataWidth   = 32,
  parameter bit           FallThrough = 1'b0,
  localparam int unsigned CntWidth    = $clog2(Depth + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumChannels-1:0]           flush_i,
  input  logic                             clr_err_i,
  input  logic [NumChannels-1:0]           push_i,
  input  logic [NumChannels*DataWidth-1:0] data_i,
  output logic [NumChannels-1:0]           full_o,
  input  logic [NumChannels-1:0]           pop_i,
  output logic [NumChannels*DataWidth-1:0] data_o,
  output logic [NumChannels-1:0]           empty_o,
  output logic [NumChannels*CntWidth-1:0]  usage_o,
  output logic [NumChannels-1:0]           overflow_o,
  output logic [NumChannels-1:0]           underflow_o
);

  localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] CntFull  = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(Depth - 1);

  // Explicit wrap so Depth need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrWidth'(1);
  endfunction

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic [DataWidth-1:0] din;
    logic                 flush;
    logic                 is_full;
    logic                 fall_thru;
    logic                 empty_vis;
    logic                 pop_acc;
    logic                 bypass;
    logic                 push_acc;
    logic                 pop_mem;
    logic                 ovf_set;
    logic                 unf_set;
    logic [DataWidth-1:0] head;

    assign din   = data_i[c*DataWidth +: DataWidth];
    assign flush = flush_i[c];

    // Handshake decode. A fall-through channel looks non-empty whenever a
    // push is presented to it while it holds nothing.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
      is_full   = (count_q == CntFull);
      fall_thru = FallThrough && (count_q == '0) && push_i[c];
      empty_vis = (count_q == '0) && !fall_thru;
      pop_acc   = pop_i[c] && !empty_vis && !flush;
      bypass    = fall_thru && pop_acc;
      push_acc  = push_i[c] && (!is_full || pop_acc) && !flush && !bypass;
      pop_mem   = pop_acc && !bypass;
      ovf_set   = push_i[c] && is_full && !pop_acc && !flush;
      unf_set   = pop_i[c] && empty_vis && !flush;
    end

    always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else begin
        if (push_acc) wr_ptr_d = ptr_next(wr_ptr_q);
        if (pop_mem)  rd_ptr_d = ptr_next(rd_ptr_q);
        if (push_acc && !pop_mem)      count_d = count_q + CntWidth'(1);
        else if (!push_acc && pop_mem) count_d = count_q - CntWidth'(1);
      end
      // A fresh error outranks a simultaneous clear.
      ovf_d = (ovf_q && !clr_err_i) || ovf_set;
      unf_d = (unf_q && !clr_err_i) || unf_set;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end else begin
        count_q  <= count_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end

    // NOTE: storage is reset too, so a fresh channel never exposes stale data.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else if (push_acc) begin
        mem_q[wr_ptr_q] <= din;
      end
    end

    always_comb begin
      head = '0;
      if (!empty_vis) head = fall_thru ? din : mem_q[rd_ptr_q];
    end

    assign data_o[c*DataWidth +: DataWidth] = head;
    assign usage_o[c*CntWidth +: CntWidth]  = count_q;
    assign full_o[c]      = is_full;
    assign empty_o[c]     = empty_vis;
    assign overflow_o[c]  = ovf_q;
    assign underflow_o[c] = unf_q;
  end

endmodule

// File: tb/tb_auteur_mc_fifo.sv
// Scoreboard bench for auteur_mc_fifo: default bank, a Depth=5 bank for
// pointer wrap, and a fall-through bank.
module tb_auteur_mc_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main bank: 4 ch x 8 deep x 32 bit
  logic [3:0]   m_flush, m_push, m_pop, m_full, m_empty, m_ovf, m_unf;
  logic         m_clr;
  logic [127:0] m_din, m_dout;
  logic [15:0]  m_usage;

  // Wrap bank: 1 ch x 5 deep x 8 bit
  logic       d_flush, d_push, d_pop, d_full, d_empty, d_ovf, d_unf, d_clr;
  logic [7:0] d_din, d_dout;
  logic [2:0] d_usage;

  // Fall-through bank: 2 ch x 4 deep x 8 bit
  logic [1:0]  f_flush, f_push, f_pop, f_full, f_empty, f_ovf, f_unf;
  logic        f_clr;
  logic [15:0] f_din, f_dout;
  logic [5:0]  f_usage;

  auteur_mc_fifo #(.NumChannels(4), .Depth(8), .DataWidth(32), .FallThrough(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(m_flush), .clr_err_i(m_clr),
    .push_i(m_push), .data_i(m_din), .full_o(m_full), .pop_i(m_pop),
    .data_o(m_dout), .empty_o(m_empty), .usage_o(m_usage),
    .overflow_o(m_ovf), .underflow_o(m_unf)
  );

  auteur_mc_fifo #(.NumChannels(1), .Depth(5), .DataWidth(8), .FallThrough(1'b0)) dut5 (
    .clk_i(clk), .rst_i(rst), .flush_i(d_flush), .clr_err_i(d_clr),
    .push_i(d_push), .data_i(d_din), .full_o(d_full), .pop_i(d_pop),
    .data_o(d_dout), .empty_o(d_empty), .usage_o(d_usage),
    .overflow_o(d_ovf), .underflow_o(d_unf)
  );

  auteur_mc_fifo #(.NumChannels(2), .Depth(4), .DataWidth(8), .FallThrough(1'b1)) dut_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(f_flush), .clr_err_i(f_clr),
    .push_i(f_push), .data_i(f_din), .full_o(f_full), .pop_i(f_pop),
    .data_o(f_dout), .empty_o(f_empty), .usage_o(f_usage),
    .overflow_o(f_ovf), .underflow_o(f_unf)
  );

  function automatic logic [31:0] m_dch(input int c);
    return m_dout[c*32 +: 32];
  endfunction

  function automatic logic [3:0] m_use(input int c);
    return m_usage[c*4 +: 4];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_flush = '0; m_push = '0; m_pop = '0; m_clr = 1'b0; m_din = '0;
    d_flush = 1'b0; d_push = 1'b0; d_pop = 1'b0; d_clr = 1'b0; d_din = '0;
    f_flush = '0; f_push = '0; f_pop = '0; f_clr = 1'b0; f_din = '0;
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_checks++;
    if (m_empty !== 4'hF) begin n_fail++; $display("FAIL reset empty: got %h want f", m_empty); end
    n_checks++;
    if (m_full !== 4'h0 || m_usage !== 16'h0) begin
      n_fail++; $display("FAIL reset full/usage: got %h/%h want 0/0", m_full, m_usage);
    end
    n_checks++;
    if (m_dout !== 128'h0 || m_ovf !== 4'h0 || m_unf !== 4'h0) begin
      n_fail++; $display("FAIL reset data/flags: got %h %h %h want 0", m_dout, m_ovf, m_unf);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill_drain();
    logic [31:0] q[$];
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      m_push[0] = 1'b1;
      m_din[31:0] = 32'hA0 + 32'(i);
      q.push_back(32'hA0 + 32'(i));
      step();
    end
    idle();
    #1;
    n_checks++;
    if (m_full[0] !== 1'b1 || m_use(0) !== 4'd8) begin
      n_fail++; $display("FAIL fill full/usage: got %b/%0d want 1/8", m_full[0], m_use(0));
    end
    n_checks++;
    if (m_empty[3:1] !== 3'b111 || m_usage[15:4] !== 12'h0) begin
      n_fail++; $display("FAIL fill others: got empty %b usage %h want 111/0", m_empty[3:1], m_usage[15:4]);
    end
    for (int i = 0; i < 8; i++) begin
      m_pop[0] = 1'b1;
      #1;
      exp = q.pop_front();
      n_checks++;
      if (m_dch(0) !== exp) begin n_fail++; $display("FAIL drain data %0d: got %h want %h", i, m_dch(0), exp); end
      step();
    end
    idle();
    #1;
    n_checks++;
    if (m_empty[0] !== 1'b1 || m_dch(0) !== 32'h0) begin
      n_fail++; $display("FAIL drain empty: got %b/%h want 1/0", m_empty[0], m_dch(0));
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        d_push = 1'b1;
        d_din = 8'(8'h10 + 3*r + k);
        q.push_back(8'(8'h10 + 3*r + k));
        step();
      end
      d_push = 1'b0;
      for (int k = 0; k < 3; k++) begin
        d_pop = 1'b1;
        #1;
        exp = q.pop_front();
        n_checks++;
        if (d_dout !== exp) begin n_fail++; $display("FAIL wrap data r%0d k%0d: got %h want %h", r, k, d_dout, exp); end
        step();
      end
      d_pop = 1'b0;
    end
    idle();
    #1;
    n_checks++;
    if (d_ovf !== 1'b0 || d_unf !== 1'b0 || d_usage !== 3'd0 || d_empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap end: got ovf %b unf %b usage %0d empty %b want 0 0 0 1", d_ovf, d_unf, d_usage, d_empty);
    end
  endtask

  task automatic test_overflow_and_full_push_pop();
    logic [31:0] q[$];
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      m_push[2] = 1'b1;
      m_din[95:64] = 32'h20 + 32'(i);
      q.push_back(32'h20 + 32'(i));
      step();
    end
    m_din[95:64] = 32'hFF;
    step();
    idle();
    #1;
    n_checks++;
    if (m_ovf[2] !== 1'b1) begin n_fail++; $display("FAIL overflow flag: got %b want 1", m_ovf[2]); end
    n_checks++;
    if (m_use(2) !== 4'd8 || m_dch(2) !== q[0]) begin
      n_fail++; $display("FAIL overflow head: got usage %0d head %h want 8 %h", m_use(2), m_dch(2), q[0]);
    end
    m_clr = 1'b1;
    step();
    idle();
    #1;
    n_checks++;
    if (m_ovf[2] !== 1'b0) begin n_fail++; $display("FAIL overflow clear: got %b want 0", m_ovf[2]); end
    // Full channel, push and pop together
    m_push[2] = 1'b1;
    m_pop[2] = 1'b1;
    m_din[95:64] = 32'hFF;
    #1;
    exp = q.pop_front();
    q.push_back(32'hFF);
    n_checks++;
    if (m_dch(2) !== exp) begin n_fail++; $display("FAIL full push_pop head: got %h want %h", m_dch(2), exp); end
    step();
    idle();
    #1;
    n_checks++;
    if (m_use(2) !== 4'd8 || m_full[2] !== 1'b1 || m_ovf[2] !== 1'b0) begin
      n_fail++; $display("FAIL full push_pop status: got usage %0d full %b ovf %b want 8 1 0", m_use(2), m_full[2], m_ovf[2]);
    end
    for (int i = 0; i < 8; i++) begin
      m_pop[2] = 1'b1;
      #1;
      exp = q.pop_front();
      n_checks++;
      if (m_dch(2) !== exp) begin n_fail++; $display("FAIL full push_pop drain %0d: got %h want %h", i, m_dch(2), exp); end
      step();
    end
    idle();
    #1;
    n_checks++;
    if (m_empty[2] !== 1'b1) begin n_fail++; $display("FAIL full push_pop empty: got %b want 1", m_empty[2]); end
  endtask

  task automatic test_underflow();
    m_pop[3] = 1'b1;
    step();
    idle();
    #1;
    n_checks++;
    if (m_unf[3] !== 1'b1 || m_use(3) !== 4'd0) begin
      n_fail++; $display("FAIL underflow set: got unf %b usage %0d want 1 0", m_unf[3], m_use(3));
    end
    m_clr = 1'b1;
    m_pop[3] = 1'b1;
    step();
    idle();
    #1;
    n_checks++;
    if (m_unf[3] !== 1'b1) begin n_fail++; $display("FAIL underflow clr race: got %b want 1", m_unf[3]); end
    m_clr = 1'b1;
    step();
    idle();
    #1;
    n_checks++;
    if (m_unf[3] !== 1'b0) begin n_fail++; $display("FAIL underflow clear: got %b want 0", m_unf[3]); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      m_push[1] = 1'b1;
      m_din[63:32] = 32'h30 + 32'(i);
      step();
    end
    idle();
    #1;
    n_checks++;
    if (m_use(1) !== 4'd3) begin n_fail++; $display("FAIL flush pre usage: got %0d want 3", m_use(1)); end
    m_flush[1] = 1'b1;
    m_push[1] = 1'b1;
    m_din[63:32] = 32'hEE;
    step();
    idle();
    #1;
    n_checks++;
    if (m_use(1) !== 4'd0 || m_empty[1] !== 1'b1) begin
      n_fail++; $display("FAIL flush status: got usage %0d empty %b want 0 1", m_use(1), m_empty[1]);
    end
    n_checks++;
    if (m_ovf[1] !== 1'b0 || m_unf[1] !== 1'b0) begin
      n_fail++; $display("FAIL flush flags: got ovf %b unf %b want 0 0", m_ovf[1], m_unf[1]);
    end
  endtask

  task automatic test_fall_through();
    logic [7:0] q[$];
    logic [7:0] exp;
    f_push[0] = 1'b1;
    f_pop[0] = 1'b1;
    f_din[7:0] = 8'h55;
    #1;
    n_checks++;
    if (f_dout[7:0] !== 8'h55 || f_empty[0] !== 1'b0) begin
      n_fail++; $display("FAIL ft bypass comb: got %h empty %b want 55 0", f_dout[7:0], f_empty[0]);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (f_usage[2:0] !== 3'd0 || f_unf[0] !== 1'b0 || f_empty[0] !== 1'b1) begin
      n_fail++; $display("FAIL ft bypass after: got usage %0d unf %b empty %b want 0 0 1", f_usage[2:0], f_unf[0], f_empty[0]);
    end
    f_push[0] = 1'b1;
    f_din[7:0] = 8'h66;
    q.push_back(8'h66);
    #1;
    n_checks++;
    if (f_dout[7:0] !== 8'h66) begin n_fail++; $display("FAIL ft push comb: got %h want 66", f_dout[7:0]); end
    step();
    idle();
    #1;
    n_checks++;
    if (f_usage[2:0] !== 3'd1) begin n_fail++; $display("FAIL ft push usage: got %0d want 1", f_usage[2:0]); end
    f_pop[0] = 1'b1;
    #1;
    exp = q.pop_front();
    n_checks++;
    if (f_dout[7:0] !== exp) begin n_fail++; $display("FAIL ft pop data: got %h want %h", f_dout[7:0], exp); end
    step();
    f_pop[0] = 1'b1;
    step();
    idle();
    #1;
    n_checks++;
    if (f_unf[0] !== 1'b1 || f_empty[0] !== 1'b1) begin
      n_fail++; $display("FAIL ft underflow: got unf %b empty %b want 1 1", f_unf[0], f_empty[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      m_push = 4'b0011;
      m_pop[3] = 1'b1;
      m_din[31:0] = 32'h40 + 32'(i);
      m_din[63:32] = 32'h50 + 32'(i);
      step();
    end
    n_checks++;
    if (m_unf[3] !== 1'b1 || m_use(0) !== 4'd3) begin
      n_fail++; $display("FAIL burst pre-reset: got unf %b usage %0d want 1 3", m_unf[3], m_use(0));
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_empty !== 4'hF || m_full !== 4'h0 || m_usage !== 16'h0) begin
      n_fail++; $display("FAIL async reset status: got empty %h full %h usage %h want f 0 0", m_empty, m_full, m_usage);
    end
    n_checks++;
    if (m_dout !== 128'h0 || m_ovf !== 4'h0 || m_unf !== 4'h0) begin
      n_fail++; $display("FAIL async reset data/flags: got %h %h %h want 0", m_dout, m_ovf, m_unf);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();
    m_push[0] = 1'b1;
    m_din[31:0] = 32'h77;
    step();
    idle();
    #1;
    n_checks++;
    if (m_dch(0) !== 32'h77 || m_use(0) !== 4'd1) begin
      n_fail++; $display("FAIL post-reset push: got %h usage %0d want 77 1", m_dch(0), m_use(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_overflow_and_full_push_pop();
    test_underflow();
    test_flush();
    test_fall_through();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/auteur_mc_fifo.md
Name: auteur_mc_fifo

Overview:
- Multi-channel, parametrised FIFO bank: NumChannels independent circular queues, each Depth entries of DataWidth bits, in one instance.
- Per-channel full/empty/usage status and sticky overflow/underflow flags.
- Illegal pushes and pops are detected and made harmless, not silently corrupting pointers.
- Optional fall-through mode.
- Sits between the AXI-side request splitter and the per-port engines; one channel per port.

Parameters:
- NumChannels, 4, number of independent queues (>=1)
- Depth, 8, entries per channel (>=2, need not be a power of two)
- DataWidth, 32, bits per entry
- FallThrough, 0, 1 = empty channel forwards data_i combinationally to data_o in the same cycle
- CntWidth, $clog2(Depth+1), localparam, width of each usage field

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  NumChannels  per-channel synchronous flush
- clr_err_i  in  1  clears all sticky error flags
- push_i  in  NumChannels  per-channel push request
- data_i  in  NumChannels*DataWidth  push data, channel c at [c*DataWidth +: DataWidth]
- full_o  out  NumChannels  channel holds Depth entries
- pop_i  in  NumChannels  per-channel pop request
- data_o  out  NumChannels*DataWidth  head data per channel
- empty_o  out  NumChannels  channel holds no entries (see fall-through)
- usage_o  out  NumChannels*CntWidth  entry count per channel
- overflow_o  out  NumChannels  sticky: push attempted while full and not accepted
- underflow_o  out  NumChannels  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst_i=1):
  - All pointers, counts, memories and error flags go to 0.
  - Outputs: empty_o all 1, full_o 0, usage_o 0, data_o 0, overflow_o/underflow_o 0.
- Channels are fully independent; below, "count" is one channel's usage.
- Write/read pointers wrap from Depth-1 to 0 explicitly; no power-of-two assumption.
- Push accepted iff push_i && (!full || pop accepted in the same cycle).
  - Accepted push writes data_i at wr_ptr; wr_ptr advances at the next edge.
- Pop accepted iff pop_i && !empty_o.
  - data_o shows the head entry during that cycle; rd_ptr advances at the next edge.
- Count next = count + accepted_push - accepted_pop; usage_o is registered count.
- full_o = (count == Depth); empty_o = (count == 0), except in fall-through mode below.
- Write latency (FallThrough=0): data pushed at edge N is visible on data_o and clears empty_o after edge N (cycle N+1).
- data_o = mem[rd_ptr] when !empty_o; drives 0 when empty_o=1 (FallThrough=0).
- Full + push + pop: both accepted, count stays Depth, no overflow.
- Full + push, no pop: push dropped, memory and pointers unchanged, overflow_o set at next edge.
- Empty + pop: pop ignored, underflow_o set at next edge.
  - FallThrough=0 only: an empty-cycle push in the same cycle is still accepted.
- FallThrough=1, channel empty (count 0) and push_i=1:
  - empty_o=0 and data_o=data_i combinationally.
  - If pop_i is also 1: data bypasses storage, count stays 0, pointers unchanged, no underflow.
  - If pop_i=0: normal push.
- flush_i[c]:
  - Next edge sets count/pointers of channel c to 0.
  - push/pop on c in that cycle are ignored and raise no error flags.
  - Memory contents are not cleared.
  - Error flags are untouched.
- clr_err_i clears all sticky flags at the next edge. A new error in the same cycle wins: the flag stays 1.
- Reset asserted mid-traffic takes effect immediately, whatever the handshake state; the first edge after deassertion behaves as from empty.
- Memory write enable is gated per channel: an entry register updates only on an accepted push.

Test Plan:
- Reset, then push 0xA0..0xA7 on ch0 in 8 cycles:
  - full_o[0]=1, usage=8.
  - Pop 8 times: data_o 0xA0..0xA7 in order, then empty_o[0]=1, data_o=0.
  - ch1..3 unaffected.
- Depth=5, push 3 / pop 3 repeated 4 times:
  - Pointers wrap at 5; data order preserved (0x10..0x1B).
  - No error flags set.
- Fill ch2, then push 0xFF without pop:
  - Dropped, overflow_o[2]=1, head unchanged.
- Fill ch2, then push+pop same cycle:
  - Accepted, usage stays Depth, 0xFF appears last.
- Pop ch3 while empty:
  - underflow_o[3]=1.
- Assert clr_err_i with a new underflow on ch3 in the same cycle:
  - underflow_o[3] stays 1.
  - Next clr_err_i alone clears it.
- FallThrough=1, empty ch0, push 0x55 + pop in the same cycle:
  - data_o=0x55 that cycle, usage stays 0, no underflow.
- Push 3 on ch1, assert flush_i[1] with a simultaneous push:
  - usage_o[1]=0 and empty_o[1]=1 next cycle, no overflow.
- Assert rst_i mid-burst:
  - Outputs return to reset values immediately, asynchronously.
